// File: rtl/axi_slave_read_channel.sv
// AXI4 read-channel slave: accepts one AR burst at a time and returns its beats
// from a synchronous single-port memory, one beat every three cycles at best.
module axi_slave_read_channel #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int MEM_AW     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ARVALID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [LEN_WIDTH-1:0]  ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  output logic                  ARREADY,
  output logic                  RVALID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  RLAST,
  output logic [1:0]            RRESP,
  input  logic                  RREADY,
  output logic                  mem_ren,
  output logic [MEM_AW-1:0]     mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [1:0]            state_q,   state_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [LEN_WIDTH-1:0]  len_q,     len_d;
  logic [LEN_WIDTH-1:0]  cnt_q,     cnt_d;
  logic [1:0]            burst_q,   burst_d;
  logic                  err_slv_q, err_slv_d;
  logic                  err_dec_q, err_dec_d;
  logic                  ren_q,     ren_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;

  logic dec_s;
  logic ren_s;
  logic last_s;

  // Any address bit above the memory window makes this beat a decode error.
  assign dec_s  = |addr_q[ADDR_WIDTH-1:MEM_AW+2];
  assign ren_s  = (state_q == S_FETCH) && !err_slv_q && !dec_s;
  assign last_s = (cnt_q == len_q);

  // ARREADY is gated by rst_n so it reads low for the whole reset window.
  assign ARREADY   = rst_n && (state_q == S_IDLE);
  assign RVALID    = (state_q == S_RESP);
  assign RDATA     = rdata_q;
  assign RRESP     = rresp_q;
  assign RLAST     = (state_q == S_RESP) && last_s;
  assign mem_ren   = ren_s;
  assign mem_raddr = (state_q == S_FETCH) ? addr_q[MEM_AW+1:2] : '0;

  // Next-state logic for the burst FSM and its per-beat datapath.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    burst_d   = burst_q;
    err_slv_d = err_slv_q;
    err_dec_d = err_dec_q;
    ren_d     = ren_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (state_q)
      S_IDLE: begin
        if (ARVALID && ARREADY) begin
          addr_d    = ARADDR;
          len_d     = ARLEN;
          burst_d   = ARBURST;
          cnt_d     = '0;
          err_slv_d = (ARSIZE != SIZE_4B) || ARBURST[1];
          err_dec_d = 1'b0;
          state_d   = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        err_dec_d = dec_s;
        ren_d     = ren_s;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        // Beats that never read memory return zero data.
        if (ren_q) begin
          rdata_d = mem_rdata;
        end else begin
          rdata_d = '0;
        end
        if (err_slv_q) begin
          rresp_d = RESP_SLVERR;
        end else if (err_dec_q) begin
          rresp_d = RESP_DECERR;
        end else begin
          rresp_d = RESP_OKAY;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (RREADY && last_s) begin
          state_d = S_IDLE;
        end else if (RREADY) begin
          cnt_d = cnt_q + LEN_WIDTH'(32'd1);
          if (burst_q == BURST_INCR) begin
            addr_d = addr_q + ADDR_WIDTH'(32'd4);
          end else begin
            addr_d = addr_q;
          end
          state_d = S_FETCH;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= 2'b00;
      err_slv_q <= 1'b0;
      err_dec_q <= 1'b0;
      ren_q     <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      err_slv_q <= err_slv_d;
      err_dec_q <= err_dec_d;
      ren_q     <= ren_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: doc/axi_slave_read_channel.md
Name: axi_slave_read_channel

Overview:
AXI4 read-side slave that terminates the AR/R channels issued by the DMA read master and returns burst data from a synchronous single-port memory read port. It sits directly downstream of the master read channel on the interconnect. The block serves one outstanding burst at a time, handles RREADY backpressure, and reports per-beat error responses.

Parameters:
ADDR_WIDTH, 32, AR address width
DATA_WIDTH, 32, RDATA width; beat size fixed at 4 bytes
LEN_WIDTH, 8, ARLEN width; a burst has ARLEN+1 beats
MEM_AW, 10, memory word-address width; memory depth is 2^MEM_AW words

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ARVALID  in  1  read address valid
ARADDR  in  ADDR_WIDTH  burst start byte address
ARLEN  in  LEN_WIDTH  beats minus one
ARSIZE  in  3  beat size; only 3'b010 supported
ARBURST  in  2  00 FIXED, 01 INCR; others unsupported
ARREADY  out  1  address accept
RVALID  out  1  read data valid
RDATA  out  DATA_WIDTH  read data
RLAST  out  1  final beat of burst
RRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
RREADY  in  1  master ready
mem_ren  out  1  memory read enable
mem_raddr  out  MEM_AW  memory word address
mem_rdata  in  DATA_WIDTH  memory data, valid the cycle after mem_ren

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. Reset state is IDLE. While rst_n is low: ARREADY=0, RVALID=0, RLAST=0, RRESP=00, RDATA=0, mem_ren=0, mem_raddr=0. Beat counter, latched address, latched length and error flags reset to 0.
- Reset mid-burst abandons the burst. No further R beats are sent. The block is in IDLE on the first cycle after rst_n goes high.
- States: IDLE, FETCH, LOAD, RESP.
- IDLE:
  - ARREADY=1, no dependence on ARVALID.
  - On ARVALID&&ARREADY: latch ARADDR, ARLEN and ARBURST; set beat counter to 0; set err_slv=(ARSIZE!=3'b010)||(ARBURST[1]==1); go to FETCH.
- FETCH:
  - mem_raddr=addr_q[MEM_AW+1:2].
  - Set err_dec=|addr_q[ADDR_WIDTH-1:MEM_AW+2].
  - mem_ren=1 only if !err_slv&&!err_dec. Go to LOAD.
- LOAD:
  - If this beat's read was issued, rdata_q<=mem_rdata; otherwise rdata_q<=0.
  - rresp_q<=err_slv ? 10 : err_dec ? 11 : 00. SLVERR takes precedence over DECERR.
  - Go to RESP.
- RESP:
  - RVALID=1, RDATA=rdata_q, RRESP=rresp_q, RLAST=(beat counter==len_q).
  - RDATA, RRESP and RLAST stay stable while RVALID&&!RREADY.
  - On RVALID&&RREADY with RLAST: go to IDLE.
  - On RVALID&&RREADY without RLAST: beat counter+1; addr_q+=4 if INCR, unchanged if FIXED; go to FETCH.
- Timing: AR handshake at cycle T gives first RVALID at T+3. Each later beat gives RVALID 3 cycles after the previous R handshake. Peak throughput is 1 beat per 3 cycles.
- ARREADY is low in FETCH, LOAD and RESP. Only one burst is outstanding at a time.
- The next AR can be accepted on the cycle after the RLAST handshake.
- Address arithmetic is modulo 2^ADDR_WIDTH. The error check is per beat, so an INCR burst crossing the top of memory returns OKAY beats then DECERR beats.
- An unaligned ARADDR has addr[1:0] ignored for the memory index. addr_q keeps the full value, so increments still add 4.
- ARLEN=0 gives a single beat with RLAST=1. ARLEN=255 gives 256 beats; the counter must not overflow before compare.
- RREADY asserted with RVALID low has no effect.

Test Plan:
1. Preload mem[k]=0xA000_0000+k; AR addr 0x40, len 7, INCR, size 010, RREADY=1 → 8 beats of 0xA000_0010..0xA000_0017, all RRESP=00, RLAST only on beat 8, first RVALID 3 cycles after AR handshake.
2. Same burst with RREADY toggled by LFSR → identical data order; RDATA, RRESP and RLAST hold stable during every RVALID&&!RREADY cycle; no beat lost or duplicated.
3. AR addr 0x40, len 3, FIXED → 4 beats all 0xA000_0010, RRESP=00, RLAST on beat 4.
4. MEM_AW=10, AR addr 0xFF8, len 3, INCR → beats 1-2 OKAY with mem[1022], mem[1023]; beats 3-4 DECERR with RDATA=0 and mem_ren never asserted for them.
5. Two bursts: AR with ARSIZE=3'b011, len 1 → 2 SLVERR beats, RDATA=0, no mem_ren. Then AR with ARBURST=10 → SLVERR with precedence over an out-of-range address.
6. Assert rst_n=0 in RESP of beat 3 of an 8-beat burst → RVALID=0 on the next cycle; ARREADY=1 on the first cycle after release; a new ARLEN=0 burst then returns exactly one beat with RLAST=1.
